cmd_dispatch: RTL and testbench

CMD_DISPATCH -- requirements
Module: cmd_dispatch

---
 rtl/cmd_dispatch_if.sv | 39 +++
 rtl/cmd_dispatch.sv | 207 ++++++++++++++++++++
 tb/tb_cmd_dispatch.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_dispatch_if.sv
// cmd_dispatch_if -- bundle between the key-scan stage / ALU and cmd_dispatch.
//   SRC, DST, ALU_OP, finish : command from key-scan (finish is a level)
//   alu_req, alu_a, alu_b, alu_op, alu_ack, alu_res, alu_flags : ALU handshake
//   RES, FLAGS : registered result for display
//   busy, done, err, ovf : status (done is a pulse, err/ovf are sticky)
// Modports: slave = dispatcher side, master = environment side.
interface cmd_dispatch_if #(
  parameter int OP_W = 4
);
  logic [15:0]     SRC;
  logic [15:0]     DST;
  logic [OP_W-1:0] ALU_OP;
  logic            finish;

  logic            alu_req;
  logic [15:0]     alu_a;
  logic [15:0]     alu_b;
  logic [OP_W-1:0] alu_op;
  logic            alu_ack;
  logic [15:0]     alu_res;
  logic [3:0]      alu_flags;

  logic [15:0]     RES;
  logic [3:0]      FLAGS;
  logic            busy;
  logic            done;
  logic            err;
  logic            ovf;

  modport slave (
    input  SRC, DST, ALU_OP, finish, alu_ack, alu_res, alu_flags,
    output alu_req, alu_a, alu_b, alu_op, RES, FLAGS, busy, done, err, ovf
  );

  modport master (
    output SRC, DST, ALU_OP, finish, alu_ack, alu_res, alu_flags,
    input  alu_req, alu_a, alu_b, alu_op, RES, FLAGS, busy, done, err, ovf
  );
endinterface

// File: rtl/cmd_dispatch.sv
// cmd_dispatch -- turns key-scan "finish" edges into ALU request/acknowledge
// transactions, with a one-entry pending slot for commands that arrive while
// a transaction is in flight.
//
// Ports:
//   CLK    : system clock, rising edge
//   RESET  : asynchronous active-low reset
//   bus    : cmd_dispatch_if.slave (command in, ALU handshake, result, status)
//
// Parameters:
//   OP_W : opcode width (must match the interface)
//   TMO  : ALU acknowledge timeout in cycles, 1..65535
//
// Build option:
//   CMD_DISPATCH_TIMEOUT_EN : when defined, WAIT gives up after TMO cycles
//   without alu_ack, sets err and still completes through DONE. When not
//   defined, WAIT waits forever and err is tied low.
module cmd_dispatch #(
  parameter int OP_W = 4,
  parameter int TMO  = 255
) (
  input logic         CLK,
  input logic         RESET,
  cmd_dispatch_if.slave bus
);

  if (TMO < 1 || TMO > 65535) begin : g_tmo_chk
    $error("cmd_dispatch: TMO out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [15:0]     src;
    logic [15:0]     dst;
    logic [OP_W-1:0] op;
  } cmd_t;

  state_t state_q, state_d;

  cmd_t        cmd_in;
  cmd_t        cur_q;
  cmd_t        slot_q;
  logic        slot_full;
  logic        fin_q;
  logic        req_q;
  logic [15:0] res_q;
  logic [3:0]  flags_q;
  logic        ovf_q;

  logic cmd_edge;
  logic busy_w;
  logic load_in;
  logic load_slot;
  logic set_req;
  logic clr_req;
  logic cap_res;
  logic tmo_expired;
  logic slot_push;

  assign cmd_in   = '{src: bus.SRC, dst: bus.DST, op: bus.ALU_OP};
  // A held-high finish gives one edge only.
  assign cmd_edge = bus.finish & ~fin_q;
  assign busy_w   = (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Optional acknowledge timeout
  // ---------------------------------------------------------------------
`ifdef CMD_DISPATCH_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        err_q;

  // Counts completed WAIT cycles; restarts every time WAIT is entered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                wait_cnt <= '0;
    else if (state_q != WAIT)  wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + 16'd1;
  end

  assign tmo_expired = (state_q == WAIT) && (wait_cnt == 16'(TMO - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                           err_q <= 1'b0;
    else if (tmo_expired && !bus.alu_ack) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign tmo_expired = 1'b0;
  assign bus.err     = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_in   = 1'b0;
    load_slot = 1'b0;
    set_req   = 1'b0;
    clr_req   = 1'b0;
    cap_res   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_edge) begin
          load_in = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        set_req = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.alu_ack) begin
          cap_res = 1'b1;
          clr_req = 1'b1;
          state_d = DONE;
        end else if (tmo_expired) begin
          clr_req = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Pending command goes straight back to ISSUE, skipping IDLE.
        if (slot_full) begin
          load_slot = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) fin_q <= 1'b0;
    else        fin_q <= bus.finish;
  end

  // Operands stay put from ISSUE through WAIT; they only reload on entry.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         cur_q <= '0;
    else if (load_in)   cur_q <= cmd_in;
    else if (load_slot) cur_q <= slot_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)       req_q <= 1'b0;
    else if (set_req) req_q <= 1'b1;
    else if (clr_req) req_q <= 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      res_q   <= '0;
      flags_q <= '0;
    end else if (cap_res) begin
      res_q   <= bus.alu_res;
      flags_q <= bus.alu_flags;
    end
  end

  // Pending slot. An edge arriving in the same cycle the slot drains
  // refills it, so only an edge against a slot that stays full overflows.
  assign slot_push = cmd_edge & busy_w;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      slot_q    <= '0;
      slot_full <= 1'b0;
    end else if (slot_push && (!slot_full || load_slot)) begin
      slot_q    <= cmd_in;
      slot_full <= 1'b1;
    end else if (load_slot) begin
      slot_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                               ovf_q <= 1'b0;
    else if (slot_push && slot_full && !load_slot) ovf_q <= 1'b1;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.alu_req = req_q;
  assign bus.alu_a   = cur_q.src;
  assign bus.alu_b   = cur_q.dst;
  assign bus.alu_op  = cur_q.op;
  assign bus.RES     = res_q;
  assign bus.FLAGS   = flags_q;
  assign bus.busy    = busy_w;
  assign bus.done    = (state_q == DONE);
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
module tb_cmd_dispatch;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  cmd_dispatch_if #(.OP_W(4)) bus();

  cmd_dispatch #(.OP_W(4), .TMO(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  // Two-cycle finish pulse; push to the scoreboard only if it should execute.
  task automatic cmd(input logic [15:0] s, input logic [15:0] d, input logic [3:0] op,
                     input logic [15:0] res, input logic [3:0] fl, input bit push);
    exp_t e;
    e = '{a: s, b: d, op: op, res: res, fl: fl};
    if (push) exp_q.push_back(e);
    bus.SRC = s; bus.DST = d; bus.ALU_OP = op; bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    cyc();
  endtask

  // Wait for alu_req, pop the expected command and check the operands.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (bus.alu_req !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    if (bus.alu_req !== 1'b1) begin
      chk({tag, "_req_timeout"}, 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_req"}, 0, 1);
      return;
    end
    cur = exp_q.pop_front();
    chk({tag, "_alu_a"},  bus.alu_a,  cur.a);
    chk({tag, "_alu_b"},  bus.alu_b,  cur.b);
    chk({tag, "_alu_op"}, bus.alu_op, cur.op);
  endtask

  // Acknowledge after dly cycles, then check the done pulse and result.
  task automatic ack(input int dly, input string tag);
    repeat (dly) cyc();
    bus.alu_ack = 1'b1; bus.alu_res = cur.res; bus.alu_flags = cur.fl;
    cyc();
    bus.alu_ack = 1'b0;
    chk({tag, "_done"},  bus.done,    1);
    chk({tag, "_RES"},   bus.RES,     cur.res);
    chk({tag, "_FLAGS"}, bus.FLAGS,   cur.fl);
    chk({tag, "_req0"},  bus.alu_req, 0);
    cyc();
    chk({tag, "_done1cyc"}, bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t saved;
    RESET = 1'b1;
    bus.SRC = '0; bus.DST = '0; bus.ALU_OP = '0; bus.finish = 1'b0;
    bus.alu_ack = 1'b0; bus.alu_res = '0; bus.alu_flags = '0;
    #1 RESET = 1'b0;
    repeat (2) cyc();
    chk("rst_req",   bus.alu_req, 0);
    chk("rst_a",     bus.alu_a,   0);
    chk("rst_b",     bus.alu_b,   0);
    chk("rst_op",    bus.alu_op,  0);
    chk("rst_RES",   bus.RES,     0);
    chk("rst_FLAGS", bus.FLAGS,   0);
    chk("rst_busy",  bus.busy,    0);
    chk("rst_done",  bus.done,    0);
    chk("rst_err",   bus.err,     0);
    chk("rst_ovf",   bus.ovf,     0);
    RESET = 1'b1;
    cyc();

    // Basic transaction and latency.
    exp_q.push_back('{a: 16'h1234, b: 16'h00FF, op: 4'd3, res: 16'h1333, fl: 4'h2});
    bus.SRC = 16'h1234; bus.DST = 16'h00FF; bus.ALU_OP = 4'd3; bus.finish = 1'b1;
    cyc();
    chk("t1_req_lat1", bus.alu_req, 0);
    chk("t1_busy",     bus.busy,    1);
    bus.finish = 1'b0;
    cyc();
    chk("t1_req_lat2", bus.alu_req, 1);
    wait_req("t1");
    ack(3, "t1");
    chk("t1_idle", bus.busy, 0);

    // Second command during WAIT runs back to back.
    cmd(16'h0101, 16'h0202, 4'd1, 16'h0303, 4'h1, 1);
    wait_req("t2a");
    cmd(16'hAAAA, 16'h0055, 4'd2, 16'hAAFF, 4'h4, 1);
    ack(2, "t2a");
    chk("t2_no_idle", bus.busy,  1);
    chk("t2_alu_a",   bus.alu_a, 16'hAAAA);
    wait_req("t2b");
    ack(1, "t2b");
    chk("t2_ovf", bus.ovf, 0);

    // Edge in the same cycle the slot drains: refilled, no overflow.
    cmd(16'h1000, 16'h0001, 4'd5, 16'h1001, 4'h3, 1);
    wait_req("t3a");
    cmd(16'h2000, 16'h0002, 4'd6, 16'h2002, 4'h5, 1);
    cyc();
    bus.alu_ack = 1'b1; bus.alu_res = cur.res; bus.alu_flags = cur.fl;
    cyc();
    bus.alu_ack = 1'b0;
    chk("t3a_done", bus.done, 1);
    chk("t3a_RES",  bus.RES,  cur.res);
    exp_q.push_back('{a: 16'h3000, b: 16'h0003, op: 4'd7, res: 16'h3003, fl: 4'h6});
    bus.SRC = 16'h3000; bus.DST = 16'h0003; bus.ALU_OP = 4'd7; bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    chk("t3_no_ovf", bus.ovf,  0);
    chk("t3_busy",   bus.busy, 1);
    wait_req("t3b");
    ack(1, "t3b");
    wait_req("t3c");
    ack(1, "t3c");
    chk("t3_ovf_end", bus.ovf,  0);
    chk("t3_idle",    bus.busy, 0);
    saved = cur;

    // Stray ack while idle is ignored.
    bus.alu_ack = 1'b1; bus.alu_res = 16'hDEAD; bus.alu_flags = 4'hF;
    cyc();
    bus.alu_ack = 1'b0;
    cyc();
    chk("t4_RES",   bus.RES,   saved.res);
    chk("t4_FLAGS", bus.FLAGS, saved.fl);
    chk("t4_done",  bus.done,  0);
    chk("t4_busy",  bus.busy,  0);

    // finish held high ~20 cycles: one transaction only.
    exp_q.push_back('{a: 16'h4444, b: 16'h0004, op: 4'd8, res: 16'h4448, fl: 4'h7});
    bus.SRC = 16'h4444; bus.DST = 16'h0004; bus.ALU_OP = 4'd8; bus.finish = 1'b1;
    cyc(); cyc();
    wait_req("t5");
    ack(2, "t5");
    n = 0;
    repeat (12) begin
      cyc();
      if (bus.alu_req === 1'b1) n++;
    end
    chk("t5_one_txn", n, 0);
    bus.finish = 1'b0;
    cyc();
    chk("t5_q_empty", exp_q.size(), 0);

    // Reset during WAIT, then a late ack.
    cmd(16'h5555, 16'h0005, 4'd9, 16'h555A, 4'h8, 1);
    wait_req("t6");
    cyc();
    RESET = 1'b0;
    #1;
    chk("t6_req",  bus.alu_req, 0);
    chk("t6_busy", bus.busy,    0);
    chk("t6_RES",  bus.RES,     0);
    chk("t6_a",    bus.alu_a,   0);
    cyc();
    RESET = 1'b1;
    bus.alu_ack = 1'b1; bus.alu_res = 16'h7777; bus.alu_flags = 4'h9;
    cyc();
    bus.alu_ack = 1'b0;
    cyc();
    chk("t6_late_RES",  bus.RES,     0);
    chk("t6_late_done", bus.done,    0);
    chk("t6_late_req",  bus.alu_req, 0);

    // Three edges during one WAIT: third dropped, ovf sticky.
    cmd(16'h6000, 16'h0006, 4'd1, 16'h6006, 4'h1, 1);
    wait_req("t7a");
    cmd(16'h7000, 16'h0007, 4'd2, 16'h7007, 4'h2, 1);
    cmd(16'hCCCC, 16'h000C, 4'd3, 16'hCCD8, 4'h3, 0);
    chk("t7_ovf", bus.ovf, 1);
    ack(2, "t7a");
    wait_req("t7b");
    ack(1, "t7b");
    cyc();
    chk("t7_idle",     bus.busy, 0);
    chk("t7_ovf_hold", bus.ovf,  1);
    saved = cur;

    // Missing ack.
    cmd(16'h8000, 16'h0008, 4'd4, 16'h8008, 4'h4, 1);
    wait_req("t8");
`ifdef CMD_DISPATCH_TIMEOUT_EN
    n = 1;
    while (bus.alu_req === 1'b1 && n < 40) begin
      cyc();
      if (bus.alu_req === 1'b1) n++;
    end
    chk("t8_wait_cycles", n, 8);
    chk("t8_done", bus.done, 1);
    chk("t8_err",  bus.err,  1);
    chk("t8_RES",  bus.RES,  saved.res);
    cyc();
    chk("t8_done1cyc", bus.done, 0);
`else
    n = 0;
    repeat (30) begin
      cyc();
      if (bus.alu_req !== 1'b1) n++;
    end
    chk("t8_req_held", n, 0);
    chk("t8_err",      bus.err, 0);
    chk("t8_RES",      bus.RES, saved.res);
    ack(1, "t8");
`endif

    // Only reset clears the sticky flags.
    RESET = 1'b0;
    cyc();
    RESET = 1'b1;
    cyc();
    chk("fin_ovf", bus.ovf, 0);
    chk("fin_err", bus.err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
